// File: rtl/bus_fifo_arbiter.sv
// Round-robin burst arbiter sharing one bus_fifo write port between NUM_REQ producers.
// A requester is granted for a whole burst. Its beats are forwarded to the FIFO while
// fifo_full is low. A burst whose owner withholds req for TIMEOUT cycles is aborted.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_i                per-requester beat available
//   req_len_i            per-requester burst length (0 means 1), sampled at grant
//   req_data_i           per-requester beat data
//   req_ready_o          one-hot beat accept to the owner
//   grant_o              one-hot owner, held for the whole burst
//   fifo_wr_en_o         FIFO write strobe
//   fifo_wr_data_o       owner's data slice (0 while idle)
//   fifo_full_i          FIFO full, stalls beats
//   fifo_almost_full_i   FIFO almost full, blocks new grants
//   busy_o               burst in progress
//   abort_o              one-cycle pulse when a burst times out
module bus_fifo_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 192,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      fifo_wr_en_o,
    output logic [DATA_W-1:0]         fifo_wr_data_o,
    input  logic                      fifo_full_i,
    input  logic                      fifo_almost_full_i,
    output logic                      busy_o,
    output logic                      abort_o
);

    localparam int unsigned PtrW   = $clog2(NUM_REQ);
    localparam int unsigned StallW = $clog2(TIMEOUT + 1);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [PtrW-1:0]     owner_q;
    logic [PtrW-1:0]     rr_ptr_q;
    logic [LEN_W-1:0]    beats_left_q;
    logic [StallW-1:0]   stall_cnt_q;
    logic                abort_q;

    logic                win_found;
    logic [PtrW-1:0]     win_idx;
    logic [LEN_W-1:0]    win_len;
    logic                owner_req;
    logic                beat;
    logic [PtrW-1:0]     next_ptr;

    // First requesting index at or after rr_ptr_q, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(idx);
            end
        end
    end

    always_comb begin
        win_len = req_len_i[int'(win_idx)*LEN_W +: LEN_W];
        if (win_len == '0) begin
            win_len = LEN_W'(1);
        end
    end

    assign owner_req = req_i[owner_q];
    assign next_ptr  = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + PtrW'(1);

    // Beat is combinational so a beat can fire in the first granted cycle.
    assign beat         = (state_q == StBurst) && owner_req && !fifo_full_i && !rst_i;
    assign fifo_wr_en_o = beat;
    assign req_ready_o  = beat ? grant_q : '0;
    assign fifo_wr_data_o = (grant_q != '0) ? req_data_i[int'(owner_q)*DATA_W +: DATA_W]
                                            : '0;
    assign grant_o = grant_q;
    assign busy_o  = (state_q != StIdle);
    assign abort_o = abort_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            beats_left_q <= '0;
            stall_cnt_q  <= '0;
            abort_q      <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (win_found && !fifo_almost_full_i) begin
                        state_q      <= StBurst;
                        grant_q      <= NUM_REQ'(1) << win_idx;
                        owner_q      <= win_idx;
                        beats_left_q <= win_len;
                        stall_cnt_q  <= '0;
                    end
                end
                StBurst: begin
                    if (beat) begin
                        stall_cnt_q <= '0;
                        if (beats_left_q == LEN_W'(1)) begin
                            state_q      <= StIdle;
                            grant_q      <= '0;
                            rr_ptr_q     <= next_ptr;
                            beats_left_q <= '0;
                        end else begin
                            beats_left_q <= beats_left_q - LEN_W'(1);
                        end
                    end else if (!owner_req) begin
                        // Owner idle: count towards timeout. fifo_full alone does not.
                        if (stall_cnt_q >= StallW'(TIMEOUT - 1)) begin
                            abort_q      <= 1'b1;
                            state_q      <= StIdle;
                            grant_q      <= '0;
                            rr_ptr_q     <= next_ptr;
                            beats_left_q <= '0;
                            stall_cnt_q  <= '0;
                        end else if (stall_cnt_q != '1) begin
                            stall_cnt_q <= stall_cnt_q + StallW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_fifo_arbiter.md
# bus_fifo_arbiter

Round-robin burst arbiter that shares one `bus_fifo` write port between `NUM_REQ` producers. It grants one requester at a time for a whole burst and forwards that requester's beats to the FIFO. It throttles on FIFO `full`/`almost_full` and aborts bursts whose owner stalls too long. It sits directly in front of the FIFO's `wr_en`/`wr_data` inputs.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_W`, 192: beat width; equals FIFO `IN_DEPTH*WIDTH`.
- `LEN_W`, 4: burst-length field width.
- `TIMEOUT`, 8: stall cycles before a burst is aborted (≥1).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous active-high reset.
- `req` in NUM_REQ: per-requester "beat available".
- `req_len` in NUM_REQ*LEN_W: requested burst beats; sampled at grant; value 0 is treated as 1.
- `req_data` in NUM_REQ*DATA_W: per-requester beat data.
- `req_ready` out NUM_REQ: one-hot beat accept to the owner; low for all others.
- `grant` out NUM_REQ: one-hot owner, held for the whole burst.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_wr_data` out DATA_W: data of the owner's slice of `req_data`.
- `fifo_full` in 1: FIFO full.
- `fifo_almost_full` in 1: FIFO almost full.
- `busy` out 1: high when the state is not IDLE.
- `abort` out 1: one-cycle pulse on timeout abort.

## Operation
- States: IDLE, BURST.
- **IDLE:**
  - If any `req` is high and `fifo_almost_full` is 0, select the first requester with `req` high, searching from `rr_ptr` upward with wrap.
  - Register `grant` as one-hot for the winner.
  - Latch `beats_left = max(req_len[w],1)`, clear `stall_cnt`, and go to BURST.
  - Otherwise stay in IDLE.
- **BURST:**
  - Beat fires when `req[owner] && !fifo_full`. This is combinational: `fifo_wr_en = req_ready[owner] = beat`.
  - `fifo_wr_data` = `req_data` slice of the owner whenever `grant` is nonzero; 0 in IDLE.
  - On each beat, decrement `beats_left` and clear `stall_cnt`.
  - Last beat (`beats_left==1`): next state IDLE, `grant` goes to 0, and `rr_ptr` = (owner+1) mod NUM_REQ.
  - `fifo_full` alone never increments `stall_cnt`. `req[owner]` low increments `stall_cnt`.
  - When `stall_cnt` reaches TIMEOUT-1 and `req[owner]` is still low:
    - pulse `abort` for 1 cycle;
    - return to IDLE with `grant` = 0;
    - set `rr_ptr` = owner+1;
    - write no further beats for that burst.
- `fifo_almost_full` only gates new grants; a burst already in progress continues until `fifo_full`.
- Arithmetic:
  - `beats_left` is LEN_W bits, unsigned.
  - `stall_cnt` is `$clog2(TIMEOUT+1)` bits, saturating.
  - `rr_ptr` is `$clog2(NUM_REQ)` bits and wraps at NUM_REQ-1 → 0.
- Requesters without a grant that raise `req` are ignored. Their `req_ready` stays 0.

## Timing
- Reset values:
  - `grant` = 0, `req_ready` = 0, `fifo_wr_en` = 0, `fifo_wr_data` = 0.
  - `busy` = 0, `abort` = 0, state = IDLE.
  - `rr_ptr` = 0, `beats_left` = 0, `stall_cnt` = 0.
- Reset asserted mid-burst: at the next edge everything returns to the reset values. No `fifo_wr_en` is issued in the cycle where `rst` is high, because `fifo_wr_en` is gated by `!rst`.
- Arbitration latency: `req` high in cycle N (IDLE) → `grant` high in N+1. The first beat can fire in N+1.
- Throughput: one beat per cycle within a burst. There is exactly one IDLE cycle between consecutive bursts.
- Burst end: the last beat in cycle M → `grant` = 0 and `busy` = 0 in M+1. Arbitration for the next burst happens in M+1, with the new grant in M+2.
- `fifo_full` and `req[owner]` high in the same cycle: no beat; `stall_cnt` is unchanged.
- Abort: `req[owner]` low for TIMEOUT consecutive cycles starting at cycle S → `abort` high in cycle S+TIMEOUT together with IDLE. `abort` is registered.
- `fifo_almost_full` is sampled only in IDLE, in the arbitration cycle.

## Test plan
- **Single burst:** after reset, drive `req[2]`=1 with `req_len[2]`=3 and FIFO not full.
  - `grant` = 4'b0100 one cycle later.
  - 3 consecutive `fifo_wr_en` pulses carrying req 2's data.
  - `grant` = 0 the following cycle; `rr_ptr` = 3.
- **Round-robin fairness:** all 4 requesters held high with `req_len` = 1 each. Grant order is 0,1,2,3,0, with one IDLE cycle between grants (8 cycles per full round).
- **Back-pressure:** `req_len[1]`=4; `fifo_full`=1 for 5 cycles after the 2nd beat. The burst holds, `abort` stays 0, and the remaining 2 beats are written after `fifo_full` drops. `fifo_almost_full`=1 in IDLE blocks any new grant.
- **Timeout abort:** TIMEOUT=8, `req_len[0]`=5; `req[0]` drops after 2 beats. `abort` pulses 8 cycles later, `grant` = 0, exactly 2 writes are recorded, and requester 1 wins the next arbitration.
- **Reset mid-burst:** assert `rst` during the 2nd beat of a 6-beat burst. `fifo_wr_en` = 0 that cycle and all outputs return to 0 at the next edge. After `rst` drops, the arbiter starts from `rr_ptr` = 0.
- **Length zero:** `req_len[3]`=0. Exactly one beat is written and the burst ends normally.
